// File: rtl/lsu_bridge.sv
// lsu_bridge: load/store bridge from the core memory stage to a word-wide bus with wait states.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.

package riscv_pkg;
    typedef enum logic [3:0] {
        LOAD_STORE_NONE,
        LOAD_BYTE,
        LOAD_HALF,
        LOAD_WORD,
        LOAD_BYTE_UNSIGNED,
        LOAD_HALF_UNSIGNED,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD
    } mem_op_t;
endpackage

module lsu_bridge
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StCmd, StResp, StDone} state_t;

    state_t      state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic        timeout_hit;

    function automatic logic op_is_store(mem_op_t op);
        return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
    endfunction

    function automatic logic op_misaligned(mem_op_t op, logic [1:0] off);
        case (op)
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: return off[0];
            LOAD_WORD, STORE_WORD:                     return off != 2'b00;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Drops the low offset bits a given access size cannot use.
    function automatic logic [1:0] align_off(mem_op_t op, logic [1:0] off);
        case (op)
            LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF: return {off[1], 1'b0};
            LOAD_WORD, STORE_WORD:                     return 2'b00;
            default:                                   return off;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(mem_op_t op, logic [1:0] off);
        case (op)
            STORE_BYTE: return 4'b0001 << off;
            STORE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            STORE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(mem_op_t op, logic [31:0] wdata);
        case (op)
            STORE_BYTE: return {4{wdata[7:0]}};
            STORE_HALF: return {2{wdata[15:0]}};
            STORE_WORD: return wdata;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(mem_op_t op, logic [1:0] off, logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            LOAD_BYTE:          return {{24{b[7]}}, b};
            LOAD_HALF:          return {{16{h[15]}}, h};
            LOAD_BYTE_UNSIGNED: return {24'h0, b};
            LOAD_HALF_UNSIGNED: return {16'h0, h};
            default:            return word;
        endcase
    endfunction

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    assign req_ready = (state_q == StIdle) && !reset;
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign bus_valid = (state_q == StCmd);
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    op_d        = req_op;
                    off_d       = align_off(req_op, req_addr[1:0]);
                    rsp_data_d  = 32'h0;
                    rsp_error_d = 1'b0;
                    if (req_op == LOAD_STORE_NONE) begin
                        state_d = StDone;
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (op_misaligned(req_op, req_addr[1:0])) begin
                        state_d     = StDone;
                        rsp_error_d = 1'b1;
`endif
                    end else begin
                        state_d     = StCmd;
                        cnt_d       = 32'h0;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_we_d    = op_is_store(req_op);
                        bus_be_d    = lane_be(req_op, align_off(req_op, req_addr[1:0]));
                        bus_wdata_d = lane_wdata(req_op, req_wdata);
                    end
                end
            end
            StCmd: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_ready) begin
                    state_d = op_is_store(op_q) ? StDone : StResp;
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    rsp_error_d = 1'b1;
                end
            end
            StResp: begin
                cnt_d = cnt_q + 32'd1;
                if (bus_rvalid) begin
                    state_d    = StDone;
                    rsp_data_d = load_extract(op_q, off_q, bus_rdata);
                end else if (timeout_hit) begin
                    state_d     = StDone;
                    rsp_error_d = 1'b1;
                end
            end
            StDone: begin
                state_d     = StIdle;
                rsp_data_d  = 32'h0;
                rsp_error_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= LOAD_STORE_NONE;
            off_q       <= 2'b00;
            cnt_q       <= 32'h0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge: scoreboard of expected responses (data, error, arrival cycle)
// checked by an independent monitor; bus side driven per transaction with chosen wait states.

module tb_lsu_bridge;
    import riscv_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_bridge #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_error  (rsp_error),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // One complete operation: request, bus-side wait states, expectation pushed at acceptance.
    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int w1, input int w2, input logic [31:0] rdata);
        exp_t        e;
        int          a, guard, done_k, rv_k;
        bit          is_ld, is_st, is_b, is_h, is_w, trap, tout, to_bus, in_cmd;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wd, v;

        is_ld = op inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED};
        is_st = op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
        is_b  = op inside {LOAD_BYTE, LOAD_BYTE_UNSIGNED, STORE_BYTE};
        is_h  = op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF};
        is_w  = op inside {LOAD_WORD, STORE_WORD};
        off   = addr[1:0];
        trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (is_h && off[0]) || (is_w && off != 2'b00);
`else
        if (is_h) off[0] = 1'b0;
        if (is_w) off = 2'b00;
`endif
        to_bus = (op != LOAD_STORE_NONE) && !trap;

        be = 4'h0;
        wd = wdata;
        if (is_st && is_b) begin be = 4'b0001 << off; wd = {4{wdata[7:0]}}; end
        if (is_st && is_h) begin be = (off >= 2) ? 4'b1100 : 4'b0011; wd = {2{wdata[15:0]}}; end
        if (is_st && is_w) be = 4'b1111;

        v = rdata;
        if (is_b) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (op == LOAD_BYTE && v[7]) v = v | 32'hFFFF_FF00;
        end
        if (is_h) begin
            v = (rdata >> (8 * off)) & 32'hFFFF;
            if (op == LOAD_HALF && v[15]) v = v | 32'hFFFF_0000;
        end

        rv_k = w1 + 1 + w2;
        if (!to_bus) begin
            done_k = 0; e.data = 32'h0; e.err = trap;
        end else if (is_st) begin
            tout = (w1 >= TO);
            done_k = tout ? TO : w1 + 1; e.data = 32'h0; e.err = tout;
        end else begin
            tout = (rv_k >= TO);
            done_k = tout ? TO : rv_k + 1; e.data = tout ? 32'h0 : v; e.err = tout;
        end

        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            chk("req_accept", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
            return;
        end
        a = cyc + 1;
        e.cyc = a + done_k;
        sb.push_back(e);

        for (int k = 0; k <= done_k; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0;
                req_op    = mem_op_t'($urandom_range(0, 8));
                req_addr  = $urandom;
                req_wdata = $urandom;
            end
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            if (to_bus && k < done_k) begin
                in_cmd = (k <= w1);
                chk("bus_valid", {31'h0, bus_valid}, {31'h0, in_cmd});
                if (in_cmd) begin
                    chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                    chk("bus_we", {31'h0, bus_we}, {31'h0, is_st});
                    chk("bus_be", {28'h0, bus_be}, {28'h0, be});
                    if (is_st) chk("bus_wdata", bus_wdata, wd);
                    bus_ready = (k == w1);
                end
                if (is_ld && k == rv_k) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                end
            end else begin
                chk("bus_idle", {31'h0, bus_valid}, 32'h0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   last_a, acc;
        reset = 1'b1; req_valid = 1'b0; req_op = LOAD_STORE_NONE; req_addr = 32'h0;
        req_wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", {31'h0, req_ready}, 32'h1);

        run_op(STORE_BYTE, 32'h103, 32'h0000_00A5, 0, 0, 32'h0);
        run_op(LOAD_BYTE, 32'h202, 32'h0, 0, 3, 32'h12F3_4567);
        run_op(LOAD_BYTE_UNSIGNED, 32'h202, 32'h0, 0, 3, 32'h12F3_4567);
        run_op(LOAD_HALF_UNSIGNED, 32'h202, 32'h0, 1, 1, 32'h12F3_4567);
        run_op(LOAD_HALF, 32'h206, 32'h0, 2, 0, 32'h8001_7FFF);
        run_op(STORE_WORD, 32'h301, 32'hCAFE_BABE, 0, 0, 32'h0);
        run_op(STORE_HALF, 32'h402, 32'h0000_BEEF, 2, 0, 32'h0);
        run_op(LOAD_STORE_NONE, 32'h10, 32'h0, 0, 0, 32'h0);

        // Load that never sees bus_ready, then a stray rvalid while idle.
        run_op(LOAD_WORD, 32'h500, 32'h0, 100, 0, 32'h0);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_rvalid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while waiting in the response phase; late rvalid must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_op = LOAD_WORD; req_addr = 32'h40;
        chk("rst_test_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        run_op(LOAD_WORD, 32'h44, 32'h0, 0, 0, 32'hCAFE_F00D);

        // Back-to-back stores with req_valid held high and a zero-wait bus.
        last_a = -100;
        acc    = 0;
        @(negedge clk);
        bus_ready = 1'b1; req_valid = 1'b1; req_op = STORE_WORD;
        for (int c = 0; c < 14; c++) begin
            req_addr  = $urandom & 32'hFFFF_FFFC;
            req_wdata = $urandom;
            chk("b2b_req_ready", {31'h0, req_ready}, {31'h0, (cyc >= last_a + 2)});
            if (req_ready === 1'b1) begin
                last_a = cyc + 1;
                e.data = 32'h0; e.err = 1'b0; e.cyc = last_a + 1;
                sb.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus_ready = 1'b0;
        chk("b2b_accepts", acc, 5);

        for (int i = 0; i < 40; i++) begin
            run_op(mem_op_t'($urandom_range(0, 8)), $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), $urandom);
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
